baud_rate_gen_frac: RTL

Programmable fractional-N baud-rate generator; successor to the fixed-divisor baud tick generator.
- Produces a one-cycle oversample tick (o_tick) for the UART RX sampler.
- Produces a one-cycle bit tick (o_bit_tick) every OVERSAMPLE ticks for the UART TX shifter.
- Divisor has integer and fractional parts, loaded at run time and applied glitch-free on a period boundary.

---
 rtl/baud_gen_pkg.sv | 28 ++
 rtl/baud_rate_gen_frac_frac_accum.sv | 46 ++++
 rtl/baud_rate_gen_frac.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/baud_gen_pkg.sv
// ---------------------------------------------------------------------------
// baud_gen_pkg
// Shared types and constants for the fractional-N baud-rate generator.
//   - baud_state_t   : FSM states (ST_IDLE, ST_RUN)
//   - DIV50M_*       : integer/fractional divisors for a 50 MHz clock at x16
//   - sub_cnt_width  : width of the bit sub-counter for a given oversample
// Optional feature macro used by the generator: BAUD_GEN_RESYNC_EN
// ---------------------------------------------------------------------------
package baud_gen_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } baud_state_t;

    // 50 MHz / (16 * baud), fraction in 1/256 clock units
    localparam int DIV50M_9600_INT    = 325;
    localparam int DIV50M_9600_FRAC   = 133;
    localparam int DIV50M_19200_INT   = 162;
    localparam int DIV50M_19200_FRAC  = 195;
    localparam int DIV50M_115200_INT  = 27;
    localparam int DIV50M_115200_FRAC = 32;

    function automatic int sub_cnt_width(input int oversample);
        return $clog2(oversample);
    endfunction

endpackage

// File: rtl/baud_rate_gen_frac_frac_accum.sv
// ---------------------------------------------------------------------------
// frac_accum
// Fractional-phase accumulator for the baud generator. The accumulator
// advances by the active fraction once per tick period. The carry it reports
// is a look-ahead: the carry of the period that starts after the next update,
// using the fraction that will be active for that period.
// Ports:
//   i_clk        : clock
//   reset        : synchronous active-high reset
//   i_clear      : clear accumulator (priority over i_update)
//   i_update     : add i_frac into the accumulator (once per tick)
//   i_frac       : fraction of the period now ending
//   i_frac_next  : fraction of the period about to start
//   o_carry_next : carry out of (acc + i_frac) + i_frac_next
// ---------------------------------------------------------------------------
module frac_accum
    import baud_gen_pkg::*;
#(
    parameter int FRAC_BITS = 8
) (
    input  logic                 i_clk,
    input  logic                 reset,
    input  logic                 i_clear,
    input  logic                 i_update,
    input  logic [FRAC_BITS-1:0] i_frac,
    input  logic [FRAC_BITS-1:0] i_frac_next,
    output logic                 o_carry_next
);

    logic [FRAC_BITS-1:0] r_acc;
    logic [FRAC_BITS-1:0] w_sum;
    logic [FRAC_BITS:0]   w_sum_next;

    assign w_sum        = r_acc + i_frac;
    assign w_sum_next   = {1'b0, w_sum} + {1'b0, i_frac_next};
    assign o_carry_next = w_sum_next[FRAC_BITS];

    always_ff @(posedge i_clk) begin
        if (reset || i_clear) begin
            r_acc <= '0;
        end else if (i_update) begin
            r_acc <= w_sum;
        end
    end

endmodule

// File: rtl/baud_rate_gen_frac.sv
// ---------------------------------------------------------------------------
// baud_rate_gen_frac
// Programmable fractional-N baud-rate generator. Emits a one-cycle oversample
// tick every D or D+1 clocks (average D + frac/2^FRAC_BITS) and a bit tick on
// every OVERSAMPLE-th oversample tick. New divisors go to a shadow register
// and take effect on a period boundary.
// Optional feature macro: BAUD_GEN_RESYNC_EN adds i_resync, which restarts
// the period and puts the bit sub-counter at mid-bit.
// Ports:
//   i_clk          : clock, rising edge
//   reset          : synchronous active-high reset
//   i_resync       : (BAUD_GEN_RESYNC_EN only) realign to an RX start edge
//   i_enable       : run when high, clear and hold when low
//   i_load         : strobe, capture i_div_int / i_div_frac into shadow
//   i_div_int      : new integer divisor (0 behaves as 1)
//   i_div_frac     : new fractional divisor
//   o_tick         : oversample tick, registered
//   o_bit_tick     : bit tick, registered, coincident with an o_tick
//   o_load_pending : shadow divisor not yet applied
// ---------------------------------------------------------------------------
module baud_rate_gen_frac
    import baud_gen_pkg::*;
#(
    parameter int DIV_BITS         = 16,
    parameter int FRAC_BITS        = 8,
    parameter int OVERSAMPLE       = 16,
    parameter int DEFAULT_DIV_INT  = DIV50M_19200_INT,
    parameter int DEFAULT_DIV_FRAC = DIV50M_19200_FRAC
) (
    input  logic                 i_clk,
    input  logic                 reset,
`ifdef BAUD_GEN_RESYNC_EN
    input  logic                 i_resync,
`endif
    input  logic                 i_enable,
    input  logic                 i_load,
    input  logic [DIV_BITS-1:0]  i_div_int,
    input  logic [FRAC_BITS-1:0] i_div_frac,
    output logic                 o_tick,
    output logic                 o_bit_tick,
    output logic                 o_load_pending
);

    localparam int SUB_W = sub_cnt_width(OVERSAMPLE);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
    localparam logic [SUB_W-1:0] SUB_HALF = SUB_W'(OVERSAMPLE / 2);

    baud_state_t          r_state;
    logic [DIV_BITS-1:0]  r_act_int;
    logic [FRAC_BITS-1:0] r_act_frac;
    logic [DIV_BITS-1:0]  r_sh_int;
    logic [FRAC_BITS-1:0] r_sh_frac;
    logic                 r_pending;
    logic [DIV_BITS-1:0]  r_cnt;      // cycles remaining until the tick cycle
    logic [SUB_W-1:0]     r_sub;
    logic                 r_tick;
    logic                 r_bit_tick;

    logic [DIV_BITS-1:0]  w_int_nxt;
    logic [FRAC_BITS-1:0] w_frac_nxt;
    logic [DIV_BITS-1:0]  w_d_nxt;
    logic [DIV_BITS-1:0]  w_d_act;
    logic [DIV_BITS-1:0]  w_first_m1;
    logic [DIV_BITS-1:0]  w_resync_m1;
    logic [DIV_BITS-1:0]  w_per_m1_nxt;
    logic [SUB_W-1:0]     w_sub_inc;
    logic                 w_carry_nxt;
    logic                 w_resync;
    logic                 w_run;
    logic                 w_acc_clear;
    logic                 w_acc_update;

`ifdef BAUD_GEN_RESYNC_EN
    assign w_resync = i_resync;
`else
    assign w_resync = 1'b0;
`endif

    // Divisor in force for the period that starts after the next tick
    assign w_int_nxt    = r_pending ? r_sh_int  : r_act_int;
    assign w_frac_nxt   = r_pending ? r_sh_frac : r_act_frac;
    assign w_d_nxt      = (w_int_nxt == '0) ? DIV_BITS'(1) : w_int_nxt;
    assign w_d_act      = (r_act_int == '0) ? DIV_BITS'(1) : r_act_int;

    // A fresh start (enable or resync) has acc = 0, so its carry is always 0
    assign w_first_m1   = w_d_nxt - DIV_BITS'(1);
    assign w_resync_m1  = w_d_act - DIV_BITS'(1);
    assign w_per_m1_nxt = w_d_nxt - DIV_BITS'(1) + {{(DIV_BITS-1){1'b0}}, w_carry_nxt};
    assign w_sub_inc    = r_sub + SUB_W'(1);

    assign w_run        = (r_state == ST_RUN);
    assign w_acc_clear  = !w_run || !i_enable || w_resync;
    assign w_acc_update = w_run && r_tick;

    frac_accum #(
        .FRAC_BITS (FRAC_BITS)
    ) u_frac_accum (
        .i_clk        (i_clk),
        .reset        (reset),
        .i_clear      (w_acc_clear),
        .i_update     (w_acc_update),
        .i_frac       (r_act_frac),
        .i_frac_next  (w_frac_nxt),
        .o_carry_next (w_carry_nxt)
    );

    always_ff @(posedge i_clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_act_int  <= DIV_BITS'(DEFAULT_DIV_INT);
            r_act_frac <= FRAC_BITS'(DEFAULT_DIV_FRAC);
            r_sh_int   <= DIV_BITS'(DEFAULT_DIV_INT);
            r_sh_frac  <= FRAC_BITS'(DEFAULT_DIV_FRAC);
            r_pending  <= 1'b0;
            r_cnt      <= '0;
            r_sub      <= '0;
            r_tick     <= 1'b0;
            r_bit_tick <= 1'b0;
        end else begin
            if (i_load) begin
                r_sh_int  <= i_div_int;
                r_sh_frac <= i_div_frac;
            end
            case (r_state)
                ST_IDLE: begin
                    r_cnt      <= '0;
                    r_sub      <= '0;
                    r_tick     <= 1'b0;
                    r_bit_tick <= 1'b0;
                    if (r_pending) begin
                        r_act_int  <= r_sh_int;
                        r_act_frac <= r_sh_frac;
                    end
                    r_pending <= i_load;
                    if (i_enable) begin
                        r_state <= ST_RUN;
                        r_cnt   <= w_first_m1;
                        r_tick  <= (w_first_m1 == '0);
                    end
                end
                ST_RUN: begin
                    if (!i_enable) begin
                        r_state    <= ST_IDLE;
                        r_cnt      <= '0;
                        r_sub      <= '0;
                        r_tick     <= 1'b0;
                        r_bit_tick <= 1'b0;
                        r_pending  <= r_pending | i_load;
                    end else if (w_resync) begin
                        // Overrides any tick bookkeeping in this cycle
                        r_cnt      <= w_resync_m1;
                        r_sub      <= SUB_HALF;
                        r_tick     <= (w_resync_m1 == '0);
                        r_bit_tick <= (w_resync_m1 == '0) && (SUB_HALF == SUB_LAST);
                        r_pending  <= r_pending | i_load;
                    end else if (r_tick) begin
                        // A load arriving in a tick cycle waits for the next tick
                        if (r_pending) begin
                            r_act_int  <= r_sh_int;
                            r_act_frac <= r_sh_frac;
                        end
                        r_pending  <= i_load;
                        r_cnt      <= w_per_m1_nxt;
                        r_sub      <= w_sub_inc;
                        r_tick     <= (w_per_m1_nxt == '0);
                        r_bit_tick <= (w_per_m1_nxt == '0) && (w_sub_inc == SUB_LAST);
                    end else begin
                        r_cnt      <= r_cnt - DIV_BITS'(1);
                        r_tick     <= (r_cnt == DIV_BITS'(1));
                        r_bit_tick <= (r_cnt == DIV_BITS'(1)) && (r_sub == SUB_LAST);
                        r_pending  <= r_pending | i_load;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_tick         = r_tick;
    assign o_bit_tick     = r_bit_tick;
    assign o_load_pending = r_pending;

endmodule
